// File: rtl/aes_blk_axis_tx.sv
// aes_blk_axis_tx: buffers 128-bit AES result blocks in a small FIFO and
// serializes them onto an AXI4-Stream master, most significant word first.
// Optional build macro AES_TX_BYTE_SWAP_EN reverses the byte order of every
// outgoing word. Timing is the same with or without it.
module aes_blk_axis_tx #(
  parameter int BLK_WIDTH  = 128,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    blk_valid,
  output logic                    blk_ready,
  input  logic [BLK_WIDTH-1:0]    blk_data,
  input  logic                    blk_last,
  output logic                    m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    busy,
  output logic                    tx_done
);
  localparam int WORDS_PER_BLK = BLK_WIDTH / DATA_WIDTH;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (WORDS_PER_BLK > 1) ? $clog2(WORDS_PER_BLK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLK - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  // Block FIFO storage (no reset: contents are qualified by count)
  logic [BLK_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic                 mem_last [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 ready_en;

  // Serializer state
  state_t               state;
  logic [BLK_WIDTH-1:0] shift_reg;
  logic                 last_reg;
  logic [IDX_W-1:0]     word_idx;
  logic                 tvalid_reg;
  logic                 tx_done_reg;

  logic push;
  logic pop;
  logic hs;
  logic hs_final;
  logic fifo_empty;
  logic [DATA_WIDTH-1:0] head_word;
  logic [DATA_WIDTH-1:0] out_word;

  // ready_en keeps blk_ready low during reset and up to the first edge after it
  assign fifo_empty = (count == '0);
  assign blk_ready  = ready_en && (count != FULL_CNT);
  assign push       = blk_valid && blk_ready;
  assign hs         = tvalid_reg && m_axis_tready;
  assign hs_final   = hs && (word_idx == LAST_IDX);
  // The head is taken either by an idle serializer or back-to-back on the final word
  assign pop        = !fifo_empty && ((state == IDLE) || hs_final);

  // FIFO entry write
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= blk_data;
      mem_last[wr_ptr] <= blk_last;
    end
  end

  // FIFO pointers, occupancy and ready enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Serializer FSM: load a block, shift one word out per handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      last_reg    <= 1'b0;
      word_idx    <= '0;
      tvalid_reg  <= 1'b0;
      tx_done_reg <= 1'b0;
    end else begin
      tx_done_reg <= hs_final && last_reg;
      case (state)
        IDLE: begin
          if (pop) begin
            shift_reg  <= mem_data[rd_ptr];
            last_reg   <= mem_last[rd_ptr];
            word_idx   <= '0;
            tvalid_reg <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (hs) begin
            if (word_idx != LAST_IDX) begin
              shift_reg <= shift_reg << DATA_WIDTH;
              word_idx  <= word_idx + IDX_W'(1);
            end else if (pop) begin
              shift_reg <= mem_data[rd_ptr];
              last_reg  <= mem_last[rd_ptr];
              word_idx  <= '0;
            end else begin
              tvalid_reg <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign head_word = shift_reg[BLK_WIDTH-1 -: DATA_WIDTH];

`ifdef AES_TX_BYTE_SWAP_EN
  // Reverse byte order of the outgoing word (kernel buffer byte order)
  for (genvar gi = 0; gi < DATA_WIDTH/8; gi++) begin : g_swap
    assign out_word[gi*8 +: 8] = head_word[DATA_WIDTH-8-gi*8 +: 8];
  end
`else
  assign out_word = head_word;
`endif

  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tdata  = out_word;
  assign m_axis_tstrb  = '1;
  assign m_axis_tlast  = tvalid_reg && last_reg && (word_idx == LAST_IDX);
  assign busy          = !fifo_empty || (state == SEND);
  assign tx_done       = tx_done_reg;

endmodule

// File: doc/aes_blk_axis_tx.md
Name: aes_blk_axis_tx

Overview:
- Output-side transmitter for the AES AXI-Stream datapath. Mirror of the input packer, which packs 32-bit stream words into 128-bit AES blocks.
- Accepts 128-bit result blocks from the AES controller over a valid/ready handshake and buffers them in a small block FIFO.
- Serializes each block onto an AXI4-Stream master as 32-bit words, most significant word first.
- Asserts tlast on the final word of a block flagged as last.

Parameters:
- BLK_WIDTH, 128, AES block width in bits (`Nb * `WORD_S).
- DATA_WIDTH, 32, AXI-Stream tdata width; BLK_WIDTH must be an integer multiple of DATA_WIDTH.
- FIFO_DEPTH, 4, block FIFO entries; must be a power of 2, minimum 2.
- WORDS_PER_BLK (derived localparam) = BLK_WIDTH/DATA_WIDTH = 4.

Ports:
- clk  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-high reset.
- blk_valid  input  1  blk_data and blk_last are valid.
- blk_ready  output  1  block FIFO can accept a block.
- blk_data  input  BLK_WIDTH  AES result block; word 0 is [BLK_WIDTH-1 -: DATA_WIDTH].
- blk_last  input  1  this block ends the current frame.
- m_axis_tvalid  output  1  AXI-Stream valid.
- m_axis_tdata  output  DATA_WIDTH  AXI-Stream data.
- m_axis_tstrb  output  DATA_WIDTH/8  tied to all ones.
- m_axis_tlast  output  1  last word of the frame.
- m_axis_tready  input  1  AXI-Stream ready.
- busy  output  1  FIFO not empty, or serializer holds a block.
- tx_done  output  1  one-cycle pulse after the tlast word handshakes.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: blk_ready=0 while reset is asserted, 1 from the first edge after release; m_axis_tvalid=0; m_axis_tdata=0; m_axis_tlast=0; busy=0; tx_done=0; FIFO pointers, count and word index all cleared.
- Reset mid-frame: in-flight and buffered data are discarded. No tlast is emitted for the aborted frame.
- Block FIFO:
  - Write when blk_valid && blk_ready.
  - blk_ready = !full, where full means count==FIFO_DEPTH.
  - count width is clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous write and pop: count is unchanged and both operations take effect.
  - blk_last is stored with each entry.
- Serializer FSM, states IDLE and SEND:
  - IDLE -> SEND when the FIFO is non-empty: pop the head into a shift register, set word_idx=0, and assert tvalid from the next cycle.
  - SEND: tdata = shift register MSW.
  - On a tvalid && tready handshake with word_idx<WORDS_PER_BLK-1: shift left by DATA_WIDTH and increment word_idx.
  - On a handshake with word_idx==WORDS_PER_BLK-1:
    - FIFO non-empty: load the next block in the same edge and stay in SEND. No bubble.
    - FIFO empty: go to IDLE and deassert tvalid.
- Latency: a block handshaken at edge E into an empty, idle unit drives word 0 with tvalid high after edge E+1.
- Capacity: FIFO_DEPTH blocks in the FIFO plus 1 in the serializer.
- AXI rules:
  - Once tvalid is high, tdata and tlast hold stable until tready.
  - tvalid never depends combinationally on tready.
  - tlast = stored blk_last && word_idx==WORDS_PER_BLK-1.
- tx_done: registered; high for exactly one cycle after the edge at which the tlast word handshakes.
- busy: combinational, = (count!=0) || state==SEND.

Optional Feature:
- Macro: AES_TX_BYTE_SWAP_EN.
- Defined: each outgoing word has its bytes reversed (byte 0 <-> byte 3, byte 1 <-> byte 2), matching the kernel buffer byte order. The swap is applied at the tdata output register; timing is unchanged.
- Undefined: words are sent exactly as sliced from blk_data.

Test Plan:
- Single block, tready=1, blk_data=00112233_44556677_8899aabb_ccddeeff, blk_last=1 -> tdata 00112233, 44556677, 8899aabb, ccddeeff on 4 consecutive cycles; tlast only on ccddeeff; tx_done pulses once, one cycle later; busy returns to 0.
- Backpressure: same block, tready toggled 1,0,0,1,0,1,1 -> each word held stable while tready=0; order unchanged; exactly 4 handshakes.
- Fill: tready=0, present 6 blocks back-to-back -> 5 accepted (4 FIFO + 1 serializer); blk_ready=0 after the 5th; raise tready -> 20 words in 20 consecutive cycles with no bubbles.
- Multi-block frame: blocks A (last=0) and B (last=1), tready=1 -> 8 contiguous words; tlast only on word 8; the A->B transition has no idle cycle.
- Reset mid-frame: assert reset after word 2 of a last block -> tvalid=0, tlast=0 and busy=0 immediately; after release, a new block transmits from word 0 correctly.
- With AES_TX_BYTE_SWAP_EN defined, block 00112233_... -> first tdata 33221100; tlast and timing identical to the unswapped case.
